// File: rtl/spu_regfile_wb_if.sv
// ---------------------------------------------------------------------------
// spu_regfile_wb_if
//   Bundles the register-file signals: the two stage-8 writeback packets,
//   the register-fetch advance, the six read addresses, the six registered
//   read operands and the writeback-conflict pulse.
//
//   Packet layout, MSB first: {unit_id[UNIT_ID_SIZE], we, dest[REG_ADDR_WIDTH],
//   result[QUADWORD]}. "Bit 0" of the packet is the vector MSB.
//
//   modport master : drives packets/addresses/rd_en, observes read data
//   modport slave  : the register file itself
// ---------------------------------------------------------------------------
interface spu_regfile_wb_if #(
  parameter int UNIT_ID_SIZE   = 3,
  parameter int REG_ADDR_WIDTH = 7,
  parameter int QUADWORD       = 128
);
  localparam int PKT_W = UNIT_ID_SIZE + 1 + REG_ADDR_WIDTH + QUADWORD;

  logic [PKT_W-1:0]          wb_even_pkt;
  logic [PKT_W-1:0]          wb_odd_pkt;
  logic                      rd_en;
  logic [REG_ADDR_WIDTH-1:0] addr_ra_even;
  logic [REG_ADDR_WIDTH-1:0] addr_rb_even;
  logic [REG_ADDR_WIDTH-1:0] addr_rc_even;
  logic [REG_ADDR_WIDTH-1:0] addr_ra_odd;
  logic [REG_ADDR_WIDTH-1:0] addr_rb_odd;
  logic [REG_ADDR_WIDTH-1:0] addr_rc_odd;
  logic [QUADWORD-1:0]       ra_rd_even;
  logic [QUADWORD-1:0]       rb_rd_even;
  logic [QUADWORD-1:0]       rc_rd_even;
  logic [QUADWORD-1:0]       ra_rd_odd;
  logic [QUADWORD-1:0]       rb_rd_odd;
  logic [QUADWORD-1:0]       rc_rd_odd;
  logic                      wb_conflict;

  modport master (
    output wb_even_pkt, wb_odd_pkt, rd_en,
    output addr_ra_even, addr_rb_even, addr_rc_even,
    output addr_ra_odd, addr_rb_odd, addr_rc_odd,
    input  ra_rd_even, rb_rd_even, rc_rd_even,
    input  ra_rd_odd, rb_rd_odd, rc_rd_odd,
    input  wb_conflict
  );

  modport slave (
    input  wb_even_pkt, wb_odd_pkt, rd_en,
    input  addr_ra_even, addr_rb_even, addr_rc_even,
    input  addr_ra_odd, addr_rb_odd, addr_rc_odd,
    output ra_rd_even, rb_rd_even, rc_rd_even,
    output ra_rd_odd, rb_rd_odd, rc_rd_odd,
    output wb_conflict
  );
endinterface

// File: rtl/spu_regfile_wb.sv
// ---------------------------------------------------------------------------
// spu_regfile_wb
//   128 x 128-bit SPU register file, two writeback ports (even/odd stage-8
//   packets) and six registered read ports (ra/rb/rc, even and odd pipes).
//
// Ports
//   clk    : clock, all state on posedge
//   reset  : synchronous, active-high; clears registers, read outputs, conflict
//   bus    : spu_regfile_wb_if.slave
//            wb_even_pkt / wb_odd_pkt : {unit_id, we, dest, result}, MSB first
//            rd_en                    : 0 holds all read outputs (stall)
//            addr_{ra,rb,rc}_{even,odd} -> {ra,rb,rc}_rd_{even,odd}, 1-cycle latency
//            wb_conflict              : both pipes wrote the same register last cycle
//
// Build option
//   WB_BYPASS_EN : when defined, a read on the same edge as a write to that
//                  address returns the new data (odd wins). Otherwise the
//                  pre-write value is returned and the forwarding network
//                  supplies the new value.
//
// Six read ports plus whole-array reset rule out block RAM; the array is
// built from flops.
// ---------------------------------------------------------------------------
module spu_regfile_wb #(
  parameter int UNIT_ID_SIZE   = 3,
  parameter int REG_ADDR_WIDTH = 7,
  parameter int QUADWORD       = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  spu_regfile_wb_if.slave       bus
);
  localparam int NUM_REGS  = 2 ** REG_ADDR_WIDTH;
  localparam int PKT_W     = UNIT_ID_SIZE + 1 + REG_ADDR_WIDTH + QUADWORD;
  localparam int WE_BIT    = PKT_W - 1 - UNIT_ID_SIZE;
  localparam int DEST_MSB  = WE_BIT - 1;
  localparam int NUM_RD    = 6;

  // Packet field extraction (unit ID is not used by the register file)
  logic                      even_we;
  logic                      odd_we;
  logic [REG_ADDR_WIDTH-1:0] even_dest;
  logic [REG_ADDR_WIDTH-1:0] odd_dest;
  logic [QUADWORD-1:0]       even_data;
  logic [QUADWORD-1:0]       odd_data;

  assign even_we   = bus.wb_even_pkt[WE_BIT];
  assign odd_we    = bus.wb_odd_pkt[WE_BIT];
  assign even_dest = bus.wb_even_pkt[DEST_MSB -: REG_ADDR_WIDTH];
  assign odd_dest  = bus.wb_odd_pkt[DEST_MSB -: REG_ADDR_WIDTH];
  assign even_data = bus.wb_even_pkt[QUADWORD-1:0];
  assign odd_data  = bus.wb_odd_pkt[QUADWORD-1:0];

  logic unused_unit_id;
  assign unused_unit_id = ^{bus.wb_even_pkt[PKT_W-1 -: UNIT_ID_SIZE],
                            bus.wb_odd_pkt[PKT_W-1 -: UNIT_ID_SIZE]};

  // Register array
  logic [QUADWORD-1:0] regs_reg [NUM_REGS];

  // Odd write is issued after even so it wins on a shared destination.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      if (even_we) regs_reg[even_dest] <= even_data;
      if (odd_we)  regs_reg[odd_dest]  <= odd_data;
    end
  end

  // Writeback conflict pulse
  logic conflict_reg;
  logic conflict_next;

  assign conflict_next = even_we && odd_we && (even_dest == odd_dest);

  always_ff @(posedge clk) begin
    if (reset) conflict_reg <= 1'b0;
    else       conflict_reg <= conflict_next;
  end

  assign bus.wb_conflict = conflict_reg;

  // Read ports
  logic [REG_ADDR_WIDTH-1:0] rd_addr [NUM_RD];
  logic [QUADWORD-1:0]       rd_data [NUM_RD];

  assign rd_addr[0] = bus.addr_ra_even;
  assign rd_addr[1] = bus.addr_rb_even;
  assign rd_addr[2] = bus.addr_rc_even;
  assign rd_addr[3] = bus.addr_ra_odd;
  assign rd_addr[4] = bus.addr_rb_odd;
  assign rd_addr[5] = bus.addr_rc_odd;

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [QUADWORD-1:0] data_reg;
      logic [QUADWORD-1:0] data_next;

      always_comb begin
        data_next = regs_reg[rd_addr[gi]];
`ifdef WB_BYPASS_EN
        // Write-before-read: same-edge write data overrides the array value.
        if (odd_we && (odd_dest == rd_addr[gi])) begin
          data_next = odd_data;
        end else if (even_we && (even_dest == rd_addr[gi])) begin
          data_next = even_data;
        end
`else
        // Read-before-write: the stage-8 forwarding compare covers the
        // same-edge case, so the array value is used as is.
`endif
      end

      always_ff @(posedge clk) begin
        if (reset)          data_reg <= '0;
        else if (bus.rd_en) data_reg <= data_next;
      end

      assign rd_data[gi] = data_reg;
    end
  endgenerate

  assign bus.ra_rd_even = rd_data[0];
  assign bus.rb_rd_even = rd_data[1];
  assign bus.rc_rd_even = rd_data[2];
  assign bus.ra_rd_odd  = rd_data[3];
  assign bus.rb_rd_odd  = rd_data[4];
  assign bus.rc_rd_odd  = rd_data[5];
endmodule

// File: tb/tb_spu_regfile_wb.sv
// ---------------------------------------------------------------------------
// tb_spu_regfile_wb
//   Directed bench for spu_regfile_wb. Each cycle's expected read outputs and
//   conflict flag are computed from a reference register model when the
//   stimulus is driven, pushed to a queue, and popped/compared one edge later.
//   Follows WB_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_spu_regfile_wb;
  localparam int PW = 139;

  typedef struct {
    logic [5:0][127:0] rd;
    logic              conf;
    string             tag;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   txn;

  exp_t sb_q[$];
  logic [127:0]      mdl [128];
  logic [5:0][127:0] exp_rd;

  spu_regfile_wb_if bus ();

  spu_regfile_wb dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] obs [6];
  assign obs[0] = bus.ra_rd_even;
  assign obs[1] = bus.rb_rd_even;
  assign obs[2] = bus.rc_rd_even;
  assign obs[3] = bus.ra_rd_odd;
  assign obs[4] = bus.rb_rd_odd;
  assign obs[5] = bus.rc_rd_odd;

  function automatic logic [PW-1:0] pkt(input logic we, input logic [6:0] dest,
                                        input logic [127:0] data);
    return {3'b101, we, dest, data};
  endfunction

  function automatic logic [5:0][6:0] all_a(input logic [6:0] a);
    return {6{a}};
  endfunction

  // Drive one cycle, predict the outputs after the edge, then compare them.
  task automatic step(input string tag, input logic rst, input logic [PW-1:0] ep,
                      input logic [PW-1:0] op, input logic ren, input logic [5:0][6:0] a);
    exp_t e;
    logic         ewe, owe;
    logic [6:0]   ed, od;
    logic [127:0] edat, odat, v;
    ewe = ep[135]; ed = ep[134:128]; edat = ep[127:0];
    owe = op[135]; od = op[134:128]; odat = op[127:0];

    reset            = rst;
    bus.wb_even_pkt  = ep;
    bus.wb_odd_pkt   = op;
    bus.rd_en        = ren;
    bus.addr_ra_even = a[0];
    bus.addr_rb_even = a[1];
    bus.addr_rc_even = a[2];
    bus.addr_ra_odd  = a[3];
    bus.addr_rb_odd  = a[4];
    bus.addr_rc_odd  = a[5];

    for (int p = 0; p < 6; p++) begin
      if (rst) begin
        exp_rd[p] = '0;
      end else if (ren) begin
        v = mdl[a[p]];
`ifdef WB_BYPASS_EN
        if (owe && od == a[p])      v = odat;
        else if (ewe && ed == a[p]) v = edat;
`endif
        exp_rd[p] = v;
      end
    end
    e.rd   = exp_rd;
    e.conf = !rst && ewe && owe && (ed == od);
    e.tag  = tag;
    sb_q.push_back(e);

    if (rst) begin
      for (int i = 0; i < 128; i++) mdl[i] = '0;
    end else begin
      if (ewe) mdl[ed] = edat;
      if (owe) mdl[od] = odat;
    end

    @(posedge clk);
    #1;
    txn++;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s scoreboard got 0 entries need 1", tag);
    end else begin
      e = sb_q.pop_front();
      for (int p = 0; p < 6; p++) begin
        tests++;
        assert (obs[p] === e.rd[p]) else begin
          fails++;
          $error("FAIL %s port%0d got %h need %h", e.tag, p, obs[p], e.rd[p]);
        end
      end
      tests++;
      assert (bus.wb_conflict === e.conf) else begin
        fails++;
        $error("FAIL %s wb_conflict got %b need %b", e.tag, bus.wb_conflict, e.conf);
      end
      $display("[TB] txn %0d %s rst=%0b rd_en=%0b conf=%0b", txn, e.tag, rst, ren, bus.wb_conflict);
    end
  endtask

  initial begin
    logic [PW-1:0]      idle;
    logic [5:0][6:0]    ad;
    logic [127:0]       d_a, d_b, d_dead;
    tests = 0; fails = 0; txn = 0;
    exp_rd = '0;
    for (int i = 0; i < 128; i++) mdl[i] = '0;
    idle   = '0;
    d_a    = {4{32'hAAAA_0001}};
    d_b    = {4{32'hBBBB_0002}};
    d_dead = {4{32'hDEAD_BEEF}};

    // Reset, then sweep every address on every port
    step("reset0", 1'b1, pkt(1'b1, 7'd1, '1), idle, 1'b1, all_a(7'd1));
    step("reset1", 1'b1, idle, idle, 1'b1, all_a(7'd0));
    for (int a = 0; a < 128; a++) begin
      for (int p = 0; p < 6; p++) ad[p] = 7'((a + p * 21) % 128);
      step("sweep", 1'b0, idle, idle, 1'b1, ad);
    end

    // Single even write, then read on all six ports
    step("wr5", 1'b0, pkt(1'b1, 7'd5, {16{8'h11}}), idle, 1'b1, all_a(7'd0));
    step("rd5", 1'b0, idle, idle, 1'b1, all_a(7'd5));

    // Both pipes to reg 9: odd wins, one-cycle conflict pulse
    step("conf9", 1'b0, pkt(1'b1, 7'd9, d_a), pkt(1'b1, 7'd9, d_b), 1'b1, all_a(7'd9));
    step("rd9", 1'b0, idle, idle, 1'b1, all_a(7'd9));
    step("noconf", 1'b0, pkt(1'b1, 7'd20, d_a), pkt(1'b1, 7'd21, d_b), 1'b1,
         {7'd21, 7'd20, 7'd9, 7'd21, 7'd20, 7'd9});
    step("rd2021", 1'b0, idle, idle, 1'b1, {7'd21, 7'd20, 7'd9, 7'd21, 7'd20, 7'd9});

    // Same-edge write and read of reg 3
    step("wr_rd3", 1'b0, pkt(1'b1, 7'd3, d_dead), idle, 1'b1, all_a(7'd3));
    step("rd3", 1'b0, idle, idle, 1'b1, all_a(7'd3));

    // we=0 packets never write, including all-zero bubbles on reg 0
    step("we0_7", 1'b0, pkt(1'b0, 7'd7, '1), pkt(1'b0, 7'd7, '1), 1'b1, all_a(7'd7));
    step("rd7", 1'b0, idle, idle, 1'b1, all_a(7'd7));
    step("wr0", 1'b0, idle, pkt(1'b1, 7'd0, d_a), 1'b1, all_a(7'd0));
    step("bubble", 1'b0, idle, idle, 1'b1, all_a(7'd0));
    step("rd0", 1'b0, idle, idle, 1'b1, all_a(7'd0));

    // Stall: outputs hold while addresses and reg contents change
    step("pre_hold", 1'b0, idle, idle, 1'b1, {7'd5, 7'd9, 7'd3, 7'd0, 7'd20, 7'd21});
    step("hold1", 1'b0, pkt(1'b1, 7'd5, d_b), idle, 1'b0, all_a(7'd9));
    step("hold2", 1'b0, idle, pkt(1'b1, 7'd9, d_dead), 1'b0, all_a(7'd1));
    step("hold3", 1'b0, idle, idle, 1'b0, all_a(7'd2));
    step("unhold", 1'b0, idle, idle, 1'b1, {7'd5, 7'd9, 7'd3, 7'd0, 7'd20, 7'd21});

    // Reset mid-stream clears stored data; write in reset cycle is dropped
    step("wr12", 1'b0, pkt(1'b1, 7'd12, d_a), idle, 1'b1, all_a(7'd12));
    step("rst_mid", 1'b1, pkt(1'b1, 7'd13, d_b), pkt(1'b1, 7'd13, d_a), 1'b1, all_a(7'd12));
    step("rd12_13", 1'b0, idle, idle, 1'b1, {7'd13, 7'd12, 7'd13, 7'd12, 7'd13, 7'd12});

    // Random mixed traffic
    for (int i = 0; i < 40; i++) begin
      logic [6:0]   ed, od;
      logic [127:0] r;
      ed = 7'($urandom_range(0, 15));
      od = 7'($urandom_range(0, 15));
      r  = {$urandom, $urandom, $urandom, $urandom};
      for (int p = 0; p < 6; p++) ad[p] = 7'($urandom_range(0, 15));
      step("rand", 1'b0, pkt(1'($urandom), ed, r), pkt(1'($urandom), od, ~r),
           1'($urandom_range(0, 3) != 0), ad);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
